// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, limits, time/alarm types and FSM states for the multi-alarm RTC
package rtc_pkg;
  localparam int HOURS_W = 5;
  localparam int MINS_W = 6;
  localparam logic [HOURS_W-1:0] MAX_HH = 5'd23;
  localparam logic [MINS_W-1:0] MAX_MS = 6'd59;
  typedef struct packed {
    logic [HOURS_W-1:0] hh;
    logic [MINS_W-1:0] mm;
    logic [MINS_W-1:0] ss;
  } rtc_time_t;
  typedef struct packed {
    rtc_time_t t;
    logic en;
  } alarm_t;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;
  function automatic logic time_ok(input rtc_time_t t);
    return t.hh <= MAX_HH && t.mm <= MAX_MS && t.ss <= MAX_MS;
  endfunction
endpackage

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: divides the system clock into a one-cycle 1 Hz enable pulse
module rtc_tick_gen #(
  parameter int CLK_HZ = 125000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);
  localparam int DIV_W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_HZ - 1);
  logic [DIV_W-1:0] r_cnt;
  assign o_tick = i_run && r_cnt == LAST;
  // divider counts only while running; clear restarts a full second
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) r_cnt <= '0;
    else if (i_clear || o_tick) r_cnt <= '0;
    else if (i_run) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/rtc_alarm_multi.sv
// rtc_alarm_multi: real-time clock with N alarm channels, ring timeout, snooze and 12/24 h display
module rtc_alarm_multi import rtc_pkg::*; #(
  parameter int CLK_HZ = 125000000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS = 60,
  parameter int SNOOZE_SECS = 300,
  localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_run,
  input  logic                  i_set_time,
  input  logic [4:0]            i_set_hh,
  input  logic [5:0]            i_set_mm,
  input  logic [5:0]            i_set_ss,
  input  logic                  i_alarm_wr,
  input  logic [AW-1:0]         i_alarm_sel,
  input  logic                  i_alarm_en_in,
  input  logic                  i_ack,
  input  logic                  i_snooze,
  input  logic                  i_mode_12h,
  output logic                  o_tick_1hz,
  output logic [4:0]            o_hours,
  output logic [5:0]            o_mins,
  output logic [5:0]            o_secs,
  output logic [4:0]            o_disp_hours,
  output logic                  o_pm,
  output logic                  o_buzzer,
  output logic [NUM_ALARMS-1:0] o_alarm_hit,
  output logic                  o_set_err
);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  rtc_time_t r_time, w_next, w_set;
  alarm_t r_alarm [NUM_ALARMS];
  state_e r_state, w_state;
  logic [RW-1:0] r_ring, w_ring;
  logic [SW-1:0] r_snz, w_snz;
  logic [NUM_ALARMS-1:0] r_hit, w_hit, w_match;
  logic w_tick, w_load, w_store, w_bad, w_hit_ev, w_s_wrap, w_m_wrap, r_buzzer, r_err;
  assign w_set = '{hh: i_set_hh, mm: i_set_mm, ss: i_set_ss};
  assign w_load = i_set_time && time_ok(w_set);
  assign w_store = i_alarm_wr && time_ok(w_set) && int'(i_alarm_sel) < NUM_ALARMS;
  assign w_bad = (i_set_time && !w_load) || (i_alarm_wr && !w_store);
  rtc_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_run(i_run), .i_clear(w_load), .o_tick(w_tick)
  );
  assign w_s_wrap = r_time.ss == MAX_MS;
  assign w_m_wrap = r_time.mm == MAX_MS;
  // time value one second ahead, used both for the update and for alarm matching
  always_comb begin
    w_next.ss = w_s_wrap ? '0 : r_time.ss + 1'b1;
    w_next.mm = w_s_wrap ? (w_m_wrap ? '0 : r_time.mm + 1'b1) : r_time.mm;
    w_next.hh = (w_s_wrap && w_m_wrap) ? (r_time.hh == MAX_HH ? '0 : r_time.hh + 1'b1) : r_time.hh;
  end
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_match
    assign w_match[g] = r_alarm[g].en && r_alarm[g].t == w_next;
  end
  // a load replaces the tick's time update, so it can never fire an alarm
  assign w_hit_ev = w_tick && !w_load && |w_match;
  // alarm FSM next state; ack dominates snooze, timeout and fresh matches
  always_comb begin
    w_state = r_state;
    w_ring = r_ring;
    w_snz = r_snz;
    w_hit = w_hit_ev ? r_hit | w_match : r_hit;
    case (r_state)
      IDLE: if (w_hit_ev) begin w_state = RINGING; w_ring = '0; end
      RINGING:
        if (i_ack) begin w_state = IDLE; w_hit = '0; end
        else if (i_snooze) begin w_state = SNOOZED; w_snz = '0; end
        else if (w_hit_ev) w_ring = '0;
        else if (w_tick) begin
          w_ring = r_ring + 1'b1;
          w_state = r_ring == RW'(RING_SECS - 1) ? IDLE : RINGING;
        end
      SNOOZED:
        if (i_ack) begin w_state = IDLE; w_hit = '0; end
        else if (w_hit_ev) begin w_state = RINGING; w_ring = '0; end
        else if (w_tick) begin
          w_snz = r_snz + 1'b1;
          w_state = r_snz == SW'(SNOOZE_SECS - 1) ? RINGING : SNOOZED;
          w_ring = r_snz == SW'(SNOOZE_SECS - 1) ? '0 : r_ring;
        end
      default: w_state = IDLE;
    endcase
  end
  // time, FSM, buzzer and error pulse registers
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      r_time <= '0;
      r_state <= IDLE;
      r_ring <= '0;
      r_snz <= '0;
      r_hit <= '0;
      r_buzzer <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_time <= w_load ? w_set : w_tick ? w_next : r_time;
      r_state <= w_state;
      r_ring <= w_ring;
      r_snz <= w_snz;
      r_hit <= w_hit;
      r_buzzer <= w_state == RINGING;
      r_err <= w_bad;
    end
  // alarm channel storage
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) r_alarm[i] <= '0;
    end else if (w_store) r_alarm[i_alarm_sel] <= '{t: w_set, en: i_alarm_en_in};
  assign o_tick_1hz = w_tick;
  assign o_hours = r_time.hh;
  assign o_mins = r_time.mm;
  assign o_secs = r_time.ss;
  assign o_buzzer = r_buzzer;
  assign o_alarm_hit = r_hit;
  assign o_set_err = r_err;
  assign o_pm = r_time.hh >= 5'd12;
  assign o_disp_hours = !i_mode_12h ? r_time.hh : r_time.hh == 5'd0 ? 5'd12 :
                        r_time.hh > 5'd12 ? r_time.hh - 5'd12 : r_time.hh;
endmodule

// File: tb/tb_rtc_alarm_multi.sv
// tb_rtc_alarm_multi: directed self-checking bench for rtc_alarm_multi
module tb_rtc_alarm_multi;
  logic clk, reset_n, run, set_time, alarm_wr, alarm_en_in, ack, snooze, mode_12h;
  logic [4:0] set_hh;
  logic [5:0] set_mm, set_ss;
  logic [2:0] alarm_sel;
  logic tick_1hz, pm, buzzer, set_err;
  logic [4:0] hours, disp_hours;
  logic [5:0] mins, secs;
  logic [4:0] alarm_hit;
  int total, bad, last_n;

  rtc_alarm_multi #(.CLK_HZ(10), .NUM_ALARMS(5), .RING_SECS(3), .SNOOZE_SECS(2)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_run(run), .i_set_time(set_time),
    .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss), .i_alarm_wr(alarm_wr),
    .i_alarm_sel(alarm_sel), .i_alarm_en_in(alarm_en_in), .i_ack(ack), .i_snooze(snooze),
    .i_mode_12h(mode_12h), .o_tick_1hz(tick_1hz), .o_hours(hours), .o_mins(mins),
    .o_secs(secs), .o_disp_hours(disp_hours), .o_pm(pm), .o_buzzer(buzzer),
    .o_alarm_hit(alarm_hit), .o_set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_time = 1;
    step();
    set_time = 0;
  endtask

  task automatic pulse_alarm(input logic [2:0] sel, input logic [4:0] h, input logic [5:0] m,
                             input logic [5:0] s, input logic en);
    alarm_sel = sel; set_hh = h; set_mm = m; set_ss = s; alarm_en_in = en; alarm_wr = 1;
    step();
    alarm_wr = 0;
  endtask

  task automatic wait_tick();
    last_n = 0;
    while (!tick_1hz && last_n < 40) begin step(); last_n++; end
    total++;
    if (!tick_1hz) begin bad++; $display("FAIL tick_timeout got=none exp=tick within 40 cycles"); end
    step();
  endtask

  task automatic test_reset();
    total++;
    if ({hours, mins, secs} !== 17'd0) begin bad++; $display("FAIL reset_time got=%h exp=0", {hours, mins, secs}); end
    total++;
    if ({tick_1hz, buzzer, set_err, alarm_hit} !== 8'd0) begin bad++; $display("FAIL reset_outs got=%b exp=0", {tick_1hz, buzzer, set_err, alarm_hit}); end
  endtask

  task automatic test_rollover();
    run = 1;
    repeat (4) step();
    pulse_set(5'd23, 6'd59, 6'd58);
    total++;
    if ({hours, mins, secs} !== {5'd23, 6'd59, 6'd58}) begin bad++; $display("FAIL load_time got=%h exp=%h", {hours, mins, secs}, {5'd23, 6'd59, 6'd58}); end
    wait_tick();
    total++;
    if (last_n !== 9) begin bad++; $display("FAIL tick_after_load got=%0d exp=9", last_n); end
    total++;
    if ({hours, mins, secs} !== {5'd23, 6'd59, 6'd59}) begin bad++; $display("FAIL roll_1 got=%h exp=%h", {hours, mins, secs}, {5'd23, 6'd59, 6'd59}); end
    wait_tick();
    total++;
    if (last_n !== 9) begin bad++; $display("FAIL tick_period got=%0d exp=9", last_n); end
    total++;
    if ({hours, mins, secs} !== 17'd0) begin bad++; $display("FAIL roll_midnight got=%h exp=0", {hours, mins, secs}); end
  endtask

  task automatic test_ring();
    pulse_alarm(3'd0, 5'd0, 6'd0, 6'd5, 1'b1);
    pulse_set(5'd0, 6'd0, 6'd3);
    wait_tick();
    total++;
    if ({buzzer, hours, mins, secs} !== {1'b0, 5'd0, 6'd0, 6'd4}) begin bad++; $display("FAIL ring_pre got=%h exp=%h", {buzzer, hours, mins, secs}, {1'b0, 5'd0, 6'd0, 6'd4}); end
    wait_tick();
    total++;
    if ({buzzer, hours, mins, secs} !== {1'b1, 5'd0, 6'd0, 6'd5}) begin bad++; $display("FAIL ring_rise got=%h exp=%h", {buzzer, hours, mins, secs}, {1'b1, 5'd0, 6'd0, 6'd5}); end
    total++;
    if (alarm_hit !== 5'b00001) begin bad++; $display("FAIL ring_hit got=%b exp=00001", alarm_hit); end
    wait_tick();
    wait_tick();
    total++;
    if ({buzzer, secs} !== {1'b1, 6'd7}) begin bad++; $display("FAIL ring_hold got=%h exp=%h", {buzzer, secs}, {1'b1, 6'd7}); end
    wait_tick();
    total++;
    if ({buzzer, secs} !== {1'b0, 6'd8}) begin bad++; $display("FAIL ring_timeout got=%h exp=%h", {buzzer, secs}, {1'b0, 6'd8}); end
    total++;
    if (alarm_hit !== 5'b00001) begin bad++; $display("FAIL hit_sticky got=%b exp=00001", alarm_hit); end
  endtask

  task automatic test_snooze();
    pulse_set(5'd0, 6'd0, 6'd4);
    wait_tick();
    total++;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL snz_ring got=%b exp=1", buzzer); end
    snooze = 1;
    step();
    snooze = 0;
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL snz_quiet got=%b exp=0", buzzer); end
    wait_tick();
    total++;
    if ({buzzer, secs} !== {1'b0, 6'd6}) begin bad++; $display("FAIL snz_t1 got=%h exp=%h", {buzzer, secs}, {1'b0, 6'd6}); end
    wait_tick();
    total++;
    if ({buzzer, secs} !== {1'b1, 6'd7}) begin bad++; $display("FAIL snz_rering got=%h exp=%h", {buzzer, secs}, {1'b1, 6'd7}); end
    ack = 1; snooze = 1;
    step();
    ack = 0; snooze = 0;
    total++;
    if ({buzzer, alarm_hit} !== 6'd0) begin bad++; $display("FAIL ack_snooze got=%b exp=0", {buzzer, alarm_hit}); end
    wait_tick();
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL ack_idle got=%b exp=0", buzzer); end
  endtask

  task automatic test_multi();
    pulse_alarm(3'd1, 5'd0, 6'd1, 6'd0, 1'b1);
    pulse_alarm(3'd2, 5'd0, 6'd1, 6'd0, 1'b0);
    pulse_alarm(3'd4, 5'd0, 6'd1, 6'd0, 1'b1);
    pulse_set(5'd0, 6'd0, 6'd59);
    wait_tick();
    total++;
    if ({buzzer, alarm_hit} !== {1'b1, 5'b10010}) begin bad++; $display("FAIL multi_hit got=%b exp=110010", {buzzer, alarm_hit}); end
    total++;
    if ({hours, mins, secs} !== {5'd0, 6'd1, 6'd0}) begin bad++; $display("FAIL multi_time got=%h exp=%h", {hours, mins, secs}, {5'd0, 6'd1, 6'd0}); end
    ack = 1;
    step();
    ack = 0;
    total++;
    if ({buzzer, alarm_hit} !== 6'd0) begin bad++; $display("FAIL multi_ack got=%b exp=0", {buzzer, alarm_hit}); end
  endtask

  task automatic test_set_err();
    run = 0;
    pulse_set(5'd0, 6'd0, 6'd5);
    total++;
    if ({buzzer, set_err, hours, mins, secs} !== {2'b00, 5'd0, 6'd0, 6'd5}) begin bad++; $display("FAIL load_no_alarm got=%h exp=%h", {buzzer, set_err, hours, mins, secs}, {2'b00, 5'd0, 6'd0, 6'd5}); end
    repeat (15) step();
    total++;
    if ({tick_1hz, secs} !== {1'b0, 6'd5}) begin bad++; $display("FAIL frozen got=%h exp=%h", {tick_1hz, secs}, {1'b0, 6'd5}); end
    pulse_set(5'd1, 6'd60, 6'd0);
    total++;
    if ({set_err, hours, mins, secs} !== {1'b1, 5'd0, 6'd0, 6'd5}) begin bad++; $display("FAIL bad_set got=%h exp=%h", {set_err, hours, mins, secs}, {1'b1, 5'd0, 6'd0, 6'd5}); end
    step();
    total++;
    if (set_err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b exp=0", set_err); end
    pulse_alarm(3'd5, 5'd0, 6'd0, 6'd6, 1'b1);
    total++;
    if (set_err !== 1'b1) begin bad++; $display("FAIL bad_sel got=%b exp=1", set_err); end
    pulse_alarm(3'd3, 5'd24, 6'd0, 6'd6, 1'b1);
    total++;
    if (set_err !== 1'b1) begin bad++; $display("FAIL bad_alarm_hh got=%b exp=1", set_err); end
    pulse_alarm(3'd3, 5'd0, 6'd0, 6'd6, 1'b1);
    total++;
    if (set_err !== 1'b0) begin bad++; $display("FAIL good_alarm got=%b exp=0", set_err); end
    run = 1;
    wait_tick();
    total++;
    if ({buzzer, alarm_hit, secs} !== {1'b1, 5'b01000, 6'd6}) begin bad++; $display("FAIL ch3_hit got=%h exp=%h", {buzzer, alarm_hit, secs}, {1'b1, 5'b01000, 6'd6}); end
    ack = 1;
    step();
    ack = 0;
    run = 0;
  endtask

  task automatic test_12h();
    int hv [7] = '{0, 12, 13, 23, 11, 13, 0};
    int md [7] = '{1, 1, 1, 1, 1, 0, 0};
    int dv [7] = '{12, 12, 1, 11, 11, 13, 0};
    int pv [7] = '{0, 1, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      mode_12h = md[i][0];
      pulse_set(hv[i][4:0], 6'd30, 6'd0);
      total++;
      if ({disp_hours, pm} !== {dv[i][4:0], pv[i][0]}) begin bad++; $display("FAIL disp_%0d got=%0d/%b exp=%0d/%0d", i, disp_hours, pm, dv[i], pv[i]); end
    end
    mode_12h = 0;
  endtask

  task automatic test_async_reset();
    pulse_set(5'd0, 6'd0, 6'd59);
    run = 1;
    wait_tick();
    total++;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL pre_reset_ring got=%b exp=1", buzzer); end
    #3 reset_n = 0;
    #1;
    total++;
    if ({buzzer, alarm_hit, hours, mins, secs} !== 23'd0) begin bad++; $display("FAIL async_reset got=%h exp=0", {buzzer, alarm_hit, hours, mins, secs}); end
    #2 reset_n = 1;
    step();
    pulse_set(5'd0, 6'd0, 6'd59);
    wait_tick();
    total++;
    if ({buzzer, alarm_hit, hours, mins, secs} !== {6'd0, 5'd0, 6'd1, 6'd0}) begin bad++; $display("FAIL alarms_cleared got=%h exp=%h", {buzzer, alarm_hit, hours, mins, secs}, {6'd0, 5'd0, 6'd1, 6'd0}); end
  endtask

  initial begin
    total = 0; bad = 0; last_n = 0;
    clk = 0; reset_n = 1; run = 0; set_time = 0; alarm_wr = 0; alarm_en_in = 0;
    ack = 0; snooze = 0; mode_12h = 0; set_hh = 0; set_mm = 0; set_ss = 0; alarm_sel = 0;
    #1 reset_n = 0;
    #2;
    test_reset();
    #1 reset_n = 1;
    step();
    test_rollover();
    test_ring();
    test_snooze();
    test_multi();
    test_set_err();
    test_12h();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
